sync_event_arbiter: RTL and testbench
=====================================

Name: sync_event_arbiter

Overview:
- Single-clock (clko) scheduler that merges N single-cycle event pulses into one serial grant stream with a valid/ready handshake to a shared consumer.
- The pulses come from per-channel edge synchronizers that already land them in the clko domain.
- Per-channel pending counters prevent event loss while the consumer is busy.
- Round-robin arbitration shares the consumer fairly; sticky overflow flags report dropped events.

Parameters:
- N, 4, number of event channels; must be >= 2 (elaboration-time $error otherwise).
- CNTW, 4, pending-counter width per channel; saturates at 2**CNTW-1.
- IDW, $clog2(N), width of the channel ID (derived; not overridden).

Ports:
- clko  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ev_i  in  N  event pulses, one bit per channel, each a single clko cycle wide.
- gnt_valid  out  1  a grant is offered to the consumer.
- gnt_id  out  IDW  channel being granted; valid only while gnt_valid=1.
- gnt_ready  in  1  consumer accepts the grant; handshake occurs on a cycle with gnt_valid & gnt_ready.
- pend_any  out  1  at least one pending counter is nonzero (registered-counter OR).
- ovf  out  N  sticky per-channel overflow flags.
- ovf_clr  in  N  clears the matching ovf bit, one cycle.

Behaviour:
- Reset, asynchronous:
  - All counters = 0, ovf = 0.
  - gnt_valid = 0, gnt_id = 0, pend_any = 0.
  - State = IDLE; RR pointer = N-1, so channel 0 has first priority.
- Counter update per channel k, at each edge:
  - +1 if ev_i[k].
  - -1 if a handshake occurs with gnt_id==k.
  - Both together: value unchanged.
- Saturation:
  - Increment at 2**CNTW-1 without a simultaneous decrement: the event is dropped and ovf[k] is set at that edge.
  - Saturated with a simultaneous decrement: the count stays at max and no overflow is flagged.
- ovf set/clear precedence: set wins over ovf_clr in the same cycle.
- FSM with 2 states:
  - IDLE:
    - If any counter is nonzero, select the first nonzero channel searching from ptr+1 upward, modulo N.
    - At the next edge: gnt_id <= selected, gnt_valid <= 1, ptr <= selected, state -> OFFER.
    - Otherwise remain in IDLE with gnt_valid = 0.
  - OFFER:
    - gnt_valid and gnt_id are held stable until the handshake.
    - On handshake: decrement the granted counter, gnt_valid <= 0, state -> IDLE.
    - gnt_valid is never withdrawn without a handshake.
- Latency:
  - ev_i[k] sampled at edge E0 → counter nonzero after E0 → gnt_valid=1 after E1 (2 edges).
  - Throughput is at most 1 grant per 2 cycles; the cycle after a handshake is always IDLE (1 bubble).
- Arbitration uses registered counter values only. An event arriving in the same cycle as the arbitration decision is seen in the next IDLE.
- Fairness: with all channels continuously pending, grants cycle 0,1,...,N-1,0. No channel waits more than N grants.
- The granted channel's counter is >= 1 throughout OFFER. Increments to that channel during OFFER accumulate normally.
- pend_any is combinational from the registered counters, so it has no extra latency.
- Reset mid-OFFER: gnt_valid drops immediately (asynchronous) and all pending counts are lost; the consumer must tolerate this.
- Wrap-around: the RR search from ptr=N-1 starts at channel 0. A single pending channel equal to ptr is still found (search covers all N positions).

Decomposition:
- Shared package sync_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;
  - a localparam helper for IDW.
- One sub-module, rr_arbiter:
  - Combinational round-robin picker.
  - Inputs: req[N], ptr[IDW].
  - Outputs: any, sel[IDW].
  - Implemented by a double-width request vector and a priority search; reused by other shared-resource blocks.
- Counters, ovf flags and FSM stay in sync_event_arbiter.

Test Plan:
- Latency and basic handshake:
  - Stimulus: after reset, pulse ev_i=4'b0100 at edge 10, gnt_ready=1.
  - Required: gnt_valid=1 with gnt_id=2 after edge 11, handshake at edge 12, then pend_any=0 and gnt_valid=0.
- Fairness:
  - Stimulus: pulse ev_i=4'b1111 three times, gnt_ready=1.
  - Required: 12 grants in id order 0,1,2,3,0,1,2,3,0,1,2,3, one bubble between each.
- Backpressure:
  - Stimulus: gnt_ready=0 for 20 cycles while ev_i[1] pulses 5 times.
  - Required: gnt_id holds 1 and gnt_valid holds 1 throughout; after ready=1, exactly 5 grants of id 1.
- Saturation, CNTW=4:
  - Stimulus: 17 pulses on ev_i[3] with ready=0.
  - Required: counter 15, ovf[3]=1 on the 16th pulse, exactly 15 grants later.
  - Then: ovf_clr[3] clears it; simultaneous ovf_clr and overflow leaves ovf[3]=1.
- Simultaneous events:
  - Stimulus: ev_i[0] pulses on the same edge as a handshake of id 0 with count 1.
  - Required: count stays 1 and one further grant of id 0 follows.
- Reset mid-operation:
  - Stimulus: assert rst during OFFER with counts {2,0,3,1}.
  - Required: gnt_valid=0 immediately; after release all counts = 0, ovf = 0, the first new event on channel 0 is granted first.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared types and helpers for the event arbiter and other shared-resource blocks.
package sync_pkg;

    // Grant FSM: either searching for a pending channel or holding an offer.
    typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;

    // Channel-ID width for an n-channel block; never narrower than one bit.
    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_event_arbiter_if.sv
// Event inputs, grant handshake and status flags of the event arbiter.
interface sync_event_arbiter_if #(
    parameter int N = 4
);
    import sync_pkg::*;

    localparam int IDW = idw_f(N);

    logic [N-1:0]   ev_i;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           gnt_ready;
    logic           pend_any;
    logic [N-1:0]   ovf;
    logic [N-1:0]   ovf_clr;

    // Producer/consumer side: raises events, accepts grants, clears flags.
    modport master (
        output ev_i, gnt_ready, ovf_clr,
        input  gnt_valid, gnt_id, pend_any, ovf
    );

    // Arbiter side.
    modport slave (
        input  ev_i, gnt_ready, ovf_clr,
        output gnt_valid, gnt_id, pend_any, ovf
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N; the request at ptr itself is the last candidate.
module rr_arbiter
    import sync_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = idw_f(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] sel
);

    localparam int SW = $clog2(2 * N);

    // Two copies of the request vector let the search walk ptr+1..ptr+N
    // without a modulo on every step.
    logic [2*N-1:0] w_dbl;

    // Priority search over the N positions that follow ptr.
    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; otherwise a latch is inferred.
        w_dbl = {req, req};
        any   = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr) + i;
            if (!any && w_dbl[SW'(idx)]) begin
                any = 1'b1;
                sel = IDW'((idx >= N) ? (idx - N) : idx);
            end
        end
    end

endmodule

// File: rtl/sync_event_arbiter.sv
// Merges N single-cycle event pulses into one serial valid/ready grant stream.
// Per-channel saturating counters hold events while the consumer is busy;
// sticky overflow flags record events dropped at saturation.
module sync_event_arbiter
    import sync_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int CNTW = 4,
    localparam int IDW  = idw_f(N)
) (
    input  logic                 clko,
    input  logic                 rst,
    sync_event_arbiter_if.slave  bus
);

    if (N < 2) begin : g_param_check
        $error("sync_event_arbiter: N must be at least 2");
    end

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [CNTW-1:0] r_cnt [N];
    logic [N-1:0]    r_ovf;
    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IDW-1:0]  r_gnt_id;
    logic [IDW-1:0]  w_gnt_id_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_ptr_nxt;

    logic [N-1:0]    w_req;
    logic [N-1:0]    w_inc;
    logic [N-1:0]    w_dec;
    logic [N-1:0]    w_ovf_set;
    logic            w_hs;
    logic            w_any;
    logic [IDW-1:0]  w_sel;

    assign w_hs = (r_state == ARB_OFFER) && bus.gnt_ready;

    // Per-channel request, increment/decrement and overflow decode.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_req[k]     = (r_cnt[k] != '0);
            w_inc[k]     = bus.ev_i[k];
            w_dec[k]     = w_hs && (r_gnt_id == IDW'(k));
            w_ovf_set[k] = w_inc[k] && !w_dec[k] && (r_cnt[k] == CNT_MAX);
        end
    end

    // Pending counters: event adds one, accepted grant removes one, both cancel.
    always_ff @(posedge clko or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is real state that the arbiter reads
            // straight after reset, so every entry is cleared explicitly.
            for (int k = 0; k < N; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                // NOTE: state is updated with non-blocking assignments so all
                // channels see the pre-edge values regardless of order.
                case ({w_inc[k], w_dec[k]})
                    2'b10: if (r_cnt[k] != CNT_MAX) r_cnt[k] <= r_cnt[k] + 1'b1;
                    2'b01: r_cnt[k] <= r_cnt[k] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Sticky overflow flags; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clko or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~bus.ovf_clr) | w_ovf_set;
        end
    end

    rr_arbiter #(
        .N (N)
    ) u_rr (
        .req (w_req),
        .ptr (r_ptr),
        .any (w_any),
        .sel (w_sel)
    );

    // FSM state, held grant ID and round-robin pointer.
    always_ff @(posedge clko or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_gnt_id <= '0;
            r_ptr    <= IDW'(N - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    // Next state: pick a pending channel in IDLE, hold the offer until accepted.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt  = ARB_OFFER;
                    w_gnt_id_nxt = w_sel;
                    w_ptr_nxt    = w_sel;
                end
            end
            ARB_OFFER: begin
                if (bus.gnt_ready) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign bus.gnt_valid = (r_state == ARB_OFFER);
    assign bus.gnt_id    = r_gnt_id;
    assign bus.pend_any  = |w_req;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Directed bench for sync_event_arbiter: expected grant IDs are queued when
// events are driven and compared when the consumer accepts each grant.
module tb_sync_event_arbiter;

    logic clko;
    logic rst;

    int vectors    = 0;
    int miscompares = 0;
    int unsigned exp_q[$];
    int cyc     = 0;
    int last_hs = -10;

    sync_event_arbiter_if #(.N(4)) bus ();

    sync_event_arbiter #(
        .N    (4),
        .CNTW (4)
    ) dut (
        .clko (clko),
        .rst  (rst),
        .bus  (bus)
    );

    initial clko = 1'b0;
    always #5 clko = ~clko;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clko);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.ev_i      = '0;
        bus.gnt_ready = 1'b0;
        bus.ovf_clr   = '0;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 300;
        while ((exp_q.size() != 0 || bus.pend_any || bus.gnt_valid) && budget > 0) begin
            tick(1);
            budget--;
        end
        check(tag, (exp_q.size() == 0) && !bus.pend_any && !bus.gnt_valid, 1);
    endtask

    // Scoreboard: a handshake is visible at the falling edge before it commits.
    always @(negedge clko) begin
        cyc++;
        if (!rst && bus.gnt_valid && bus.gnt_ready) begin
            check("grant_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("grant_id", bus.gnt_id, exp_q.pop_front());
            check("grant_bubble", (cyc - last_hs) >= 2, 1);
            last_hs = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, sampled while reset is held.
        rst           = 1'b1;
        bus.ev_i      = '0;
        bus.gnt_ready = 1'b0;
        bus.ovf_clr   = '0;
        tick(2);
        check("rst_gnt_valid", bus.gnt_valid, 0);
        check("rst_gnt_id",    bus.gnt_id,    0);
        check("rst_pend_any",  bus.pend_any,  0);
        check("rst_ovf",       bus.ovf,       0);
        rst = 1'b0;
        tick(8);

        // Latency: event at E0, offer after E1, handshake at E2.
        bus.gnt_ready = 1'b1;
        bus.ev_i      = 4'b0100;
        exp_q.push_back(2);
        tick(1);
        bus.ev_i = '0;
        check("lat_pend_e0",  bus.pend_any,  1);
        check("lat_valid_e0", bus.gnt_valid, 0);
        tick(1);
        check("lat_valid_e1", bus.gnt_valid, 1);
        check("lat_id_e1",    bus.gnt_id,    2);
        tick(1);
        check("lat_valid_e2", bus.gnt_valid, 0);
        check("lat_pend_e2",  bus.pend_any,  0);
        drain("lat_drain");

        // Fairness: three rounds of all channels, served in strict rotation.
        do_reset();
        bus.gnt_ready = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) exp_q.push_back(c);
        bus.ev_i = 4'b1111;
        tick(3);
        bus.ev_i = '0;
        drain("fair_drain");

        // Backpressure: offer on channel 1 held steady for 20 cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.ev_i = ((i % 2 == 0) && (i < 10)) ? 4'b0010 : 4'b0000;
            if (bus.ev_i[1]) exp_q.push_back(1);
            tick(1);
            if (i >= 1) check("bp_hold", {bus.gnt_valid, bus.gnt_id}, {1'b1, 2'd1});
        end
        bus.ev_i      = '0;
        bus.gnt_ready = 1'b1;
        drain("bp_drain");

        // Saturation: 17 pulses on channel 3, the 16th and 17th are dropped.
        do_reset();
        for (int p = 1; p <= 17; p++) begin
            bus.ev_i = 4'b1000;
            tick(1);
            bus.ev_i = '0;
            check("sat_ovf", bus.ovf, (p >= 16) ? 4'b1000 : 4'b0000);
        end
        bus.ovf_clr = 4'b1000;
        tick(1);
        bus.ovf_clr = '0;
        check("sat_ovf_clr", bus.ovf, 4'b0000);
        bus.ev_i    = 4'b1000;
        bus.ovf_clr = 4'b1000;
        tick(1);
        bus.ev_i    = '0;
        bus.ovf_clr = '0;
        check("sat_set_wins", bus.ovf, 4'b1000);
        for (int i = 0; i < 15; i++) exp_q.push_back(3);
        bus.gnt_ready = 1'b1;
        drain("sat_drain");
        check("sat_ovf_sticky", bus.ovf, 4'b1000);

        // Event and handshake on channel 0 in the same cycle keep the count.
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(0);
        bus.ev_i = 4'b0001;
        tick(1);
        bus.ev_i = '0;
        tick(1);
        check("sim_offer", {bus.gnt_valid, bus.gnt_id}, {1'b1, 2'd0});
        bus.ev_i      = 4'b0001;
        bus.gnt_ready = 1'b1;
        tick(1);
        bus.ev_i      = '0;
        bus.gnt_ready = 1'b0;
        check("sim_pend_kept", bus.pend_any,  1);
        check("sim_bubble",    bus.gnt_valid, 0);
        bus.gnt_ready = 1'b1;
        drain("sim_drain");

        // Reset during an offer with counts ch0=2, ch1=0, ch2=3, ch3=1.
        do_reset();
        bus.ev_i = 4'b0101;
        tick(1);
        bus.ev_i = 4'b0101;
        tick(1);
        bus.ev_i = 4'b1100;
        tick(1);
        bus.ev_i = '0;
        tick(1);
        check("mid_offer", {bus.gnt_valid, bus.gnt_id}, {1'b1, 2'd0});
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid_drop", bus.gnt_valid, 0);
        check("mid_pend_clear", bus.pend_any,  0);
        check("mid_ovf_clear",  bus.ovf,       0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("mid_idle_after", bus.pend_any, 0);
        bus.gnt_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(2);
        bus.ev_i = 4'b0101;
        tick(1);
        bus.ev_i = '0;
        drain("mid_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
